// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter/sequencer for one shared add/subtract unit with registered result and flags.
// Optional fixed priority (req0 always wins contention) when ALU_ARB_FIXED_PRIO_EN is defined.
module alu_share_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HOLD} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_last_grant;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sub;
  logic             r_id;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_result;
  logic [3:0]       r_rsp_flags;

  logic             w_grant;
  logic             w_grant_vld;
  logic             w_accept;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_full;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;

  always_comb begin
    w_grant     = 1'b0;
    w_grant_vld = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      w_grant = 1'b0;
`else
      w_grant = ~r_last_grant;
`endif
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end
  end

  assign w_accept   = (r_state == S_IDLE) & w_grant_vld;
  // Gated by rst so neither requester sees a handshake while the block is held in reset.
  assign req0_ready = w_accept & ~w_grant & ~rst;
  assign req1_ready = w_accept &  w_grant & ~rst;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_vld) w_next = S_EXEC;
      S_EXEC:  w_next = S_HOLD;
      S_HOLD:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Subtraction is A + ~B + 1; carry-out of 1 then means no borrow.
  assign w_b_eff = r_sub ? ~r_b : r_b;
  assign w_full  = {1'b0, r_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, r_sub};
  assign w_sum   = w_full[WIDTH-1:0];
  assign w_ovf   = (r_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_a          <= '0;
      r_b          <= '0;
      r_sub        <= 1'b0;
      r_id         <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
    end else begin
      if (w_accept) begin
        r_a          <= w_grant ? req1_a   : req0_a;
        r_b          <= w_grant ? req1_b   : req0_b;
        r_sub        <= w_grant ? req1_sub : req0_sub;
        r_id         <= w_grant;
        r_last_grant <= w_grant;
      end
      if (r_state == S_EXEC) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_id     <= r_id;
        r_rsp_result <= w_sum;
        r_rsp_flags  <= {^w_sum, w_full[WIDTH], (w_sum == '0), w_ovf};
      end else if ((r_state == S_HOLD) && rsp_ready) begin
        r_rsp_valid  <= 1'b0;
      end
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_flags  = r_rsp_flags;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter: arithmetic/flags, arbitration, hold, reset.
module tb_alu_share_arbiter;

  logic       clk, rst;
  logic       req0_valid, req0_ready, req0_sub;
  logic [7:0] req0_a, req0_b;
  logic       req1_valid, req1_ready, req1_sub;
  logic [7:0] req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_result;
  logic [3:0] rsp_flags;

  int errors = 0;
  int checks = 0;

  alu_share_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed vectors: requester, a, b, sub, expected result, expected flags {par,c,z,v}
  logic       v_id  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [7:0] v_a   [5] = '{8'h05, 8'h80, 8'h03, 8'h2A, 8'h7F};
  logic [7:0] v_b   [5] = '{8'h03, 8'h01, 8'h05, 8'h2A, 8'h01};
  logic       v_sub [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [7:0] v_res [5] = '{8'h02, 8'h7F, 8'hFE, 8'h00, 8'h80};
  logic [3:0] v_flg [5] = '{4'b1100, 4'b1101, 4'b1000, 4'b0110, 4'b1001};

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_result !== 8'h00 || rsp_flags !== 4'h0) begin
      errors++;
      $display("FAIL reset_rsp: got v=%b id=%b r=%h f=%b want 0 0 00 0000", rsp_valid, rsp_id, rsp_result, rsp_flags);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_arith();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (v_id[i]) begin
        req1_valid = 1'b1; req1_a = v_a[i]; req1_b = v_b[i]; req1_sub = v_sub[i];
      end else begin
        req0_valid = 1'b1; req0_a = v_a[i]; req0_b = v_b[i]; req0_sub = v_sub[i];
      end
      #1;
      checks++;
      if (req0_ready !== ~v_id[i] || req1_ready !== v_id[i]) begin
        errors++; $display("FAIL arith%0d_ready: got %b%b want id %0d", i, req0_ready, req1_ready, v_id[i]);
      end
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL arith%0d_exec: got v=%b rdy=%b%b want 0 00", i, rsp_valid, req0_ready, req1_ready);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== v_res[i] || rsp_flags !== v_flg[i] || rsp_id !== v_id[i]) begin
        errors++;
        $display("FAIL arith%0d_rsp: got v=%b r=%h f=%b id=%b want 1 %h %b %b",
                 i, rsp_valid, rsp_result, rsp_flags, rsp_id, v_res[i], v_flg[i], v_id[i]);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++; $display("FAIL arith%0d_onecycle: got rsp_valid=%b want 0", i, rsp_valid);
      end
    end
  endtask

  task automatic test_contention();
    int  ngr, nrsp, last_cyc;
    logic drop, g, exp_g;
    logic [7:0] exp_r;
    ngr = 0; nrsp = 0; last_cyc = 0; drop = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req0_a = 8'h01; req0_b = 8'h01; req0_sub = 1'b0;
    req1_a = 8'h02; req1_b = 8'h03; req1_sub = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (drop) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      #1;
      if (rsp_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_g = 1'b0;
`else
        exp_g = nrsp[0];
`endif
        exp_r = exp_g ? 8'h05 : 8'h02;
        checks++;
        if (rsp_id !== exp_g || rsp_result !== exp_r) begin
          errors++; $display("FAIL rr_rsp%0d: got id=%b r=%h want %b %h", nrsp, rsp_id, rsp_result, exp_g, exp_r);
        end
        nrsp++;
      end
      if (req0_ready && req1_ready) begin
        checks++; errors++; $display("FAIL rr_both_ready: got 11 want one-hot");
      end
      if ((req0_ready || req1_ready) && ngr < 4) begin
        g = req1_ready;
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_g = 1'b0;
`else
        exp_g = ngr[0];
`endif
        checks++;
        if (g !== exp_g) begin
          errors++; $display("FAIL rr_grant%0d: got %b want %b", ngr, g, exp_g);
        end
        if (ngr > 0) begin
          checks++;
          if (cyc - last_cyc != 3) begin
            errors++; $display("FAIL rr_spacing%0d: got %0d cycles want 3", ngr, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        ngr++;
        if (ngr == 4) drop = 1'b1;
      end
      if (nrsp == 4) break;
    end
    checks++;
    if (nrsp != 4 || ngr != 4) begin
      errors++; $display("FAIL rr_timeout: got grants=%0d rsps=%0d want 4 4", ngr, nrsp);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_hold();
    logic exp_g;
    logic [7:0] exp_r;
    logic [3:0] exp_f;
    @(negedge clk);
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h10; req0_b = 8'h21; req0_sub = 1'b0;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL hold_accept: got ready0=%b want 1", req0_ready);
    end
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 8'h01; req1_b = 8'h01; req1_sub = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 8'h31 || rsp_flags !== 4'b1000 || rsp_id !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable%0d: got v=%b r=%h f=%b id=%b rdy=%b%b want 1 31 1000 0 00",
                 k, rsp_valid, rsp_result, rsp_flags, rsp_id, req0_ready, req1_ready);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_g = 1'b0;
`else
    exp_g = 1'b1;
`endif
    checks++;
    if (rsp_valid !== 1'b0 || req0_ready !== ~exp_g || req1_ready !== exp_g) begin
      errors++; $display("FAIL hold_release: got v=%b rdy=%b%b want 0 grant %b", rsp_valid, req0_ready, req1_ready, exp_g);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    #1;
    exp_r = exp_g ? 8'h00 : 8'h31;
    exp_f = exp_g ? 4'b0110 : 4'b1000;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== exp_g || rsp_result !== exp_r || rsp_flags !== exp_f) begin
      errors++;
      $display("FAIL hold_next_rsp: got v=%b id=%b r=%h f=%b want 1 %b %h %b",
               rsp_valid, rsp_id, rsp_result, rsp_flags, exp_g, exp_r, exp_f);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_exec();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h03; req0_sub = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL rstx_clear: got v=%b rdy=%b%b want 0 00", rsp_valid, req0_ready, req1_ready);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rstx_held: got rsp_valid=%b want 0", rsp_valid);
    end
    rst = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h2A; req0_b = 8'h2A; req0_sub = 1'b1;
    req1_valid = 1'b1; req1_a = 8'h7F; req1_b = 8'h01; req1_sub = 1'b0;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rstx_first_grant: got rdy=%b%b v=%b want 10 0", req0_ready, req1_ready, rsp_valid);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rstx_no_stale: got rsp_valid=%b want 0", rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 8'h00 || rsp_flags !== 4'b0110) begin
      errors++;
      $display("FAIL rstx_rsp: got v=%b id=%b r=%h f=%b want 1 0 00 0110", rsp_valid, rsp_id, rsp_result, rsp_flags);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    rsp_ready = 1'b1;
    test_reset();
    test_arith();
    test_contention();
    test_hold();
    test_reset_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
